// File: rtl/cpu_pkg.sv
// Shared CPU-side definitions: arbiter state encoding and default bus widths.
package cpu_pkg;

  localparam int DEF_AW = 32;
  localparam int DEF_DW = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    IBUSY = 2'd1,
    DBUSY = 2'd2
  } arb_state_t;

  function automatic int cnt_width(input int limit);
    return $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/ack_timer.sv
// Wait-cycle counter for the single outstanding memory transaction.
// Latency: expired_o is decoded from the registered count; clear wins over enable.
// Backpressure: none; the count saturates at TIMEOUT and never wraps.
module ack_timer
  import cpu_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int CW = cnt_width(TIMEOUT);

  logic [CW-1:0] cnt;

  assign expired_o = (cnt == CW'(TIMEOUT));

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt <= '0;
    end else if (clr_i) begin
      cnt <= '0;
    end else if (en_i && !expired_o) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates IF and MEM stage requests onto one shared memory port; data has fixed priority.
// Latency: 2 cycles minimum request-to-valid; an unanswered request is abandoned after TIMEOUT wait cycles.
// Backpressure: requesters hold req until their valid pulse; stall = req & ~valid.
module mem_arbiter
  import cpu_pkg::*;
#(
  parameter int AW      = DEF_AW,
  parameter int DW      = DEF_DW,
  parameter int TIMEOUT = 15
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          if_req_i,
  input  logic [AW-1:0] if_addr_i,
  output logic [DW-1:0] if_rdata_o,
  output logic          if_valid_o,
  output logic          if_stall_o,
  input  logic          d_req_i,
  input  logic          d_we_i,
  input  logic [AW-1:0] d_addr_i,
  input  logic [DW-1:0] d_wdata_i,
  output logic [DW-1:0] d_rdata_o,
  output logic          d_valid_o,
  output logic          d_stall_o,
  output logic          mem_req_o,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_wdata_o,
  input  logic [DW-1:0] mem_rdata_i,
  input  logic          mem_ack_i,
  output logic          err_o
);

  arb_state_t state;

  logic if_pend;
  logic d_pend;
  logic ack;
  logic expired;
  logic timeout;
  logic done;
  logic grant_d;
  logic grant_i;

  // A requester still holds req during its own valid cycle; mask it so it is not re-granted.
  assign if_pend = if_req_i & ~if_valid_o;
  assign d_pend  = d_req_i & ~d_valid_o;

  assign ack     = mem_req_o & mem_ack_i;
  assign timeout = mem_req_o & ~mem_ack_i & expired;
  assign done    = ack | timeout;

  // Completion hands straight over to the other requester; a repeat of the same one goes via IDLE.
  assign grant_d = d_pend & ((state == IDLE) | ((state == IBUSY) & done));
  assign grant_i = if_pend & (((state == IDLE) & ~d_pend) | ((state == DBUSY) & done));

  assign if_stall_o = if_req_i & ~if_valid_o;
  assign d_stall_o  = d_req_i & ~d_valid_o;

  ack_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_ack_timer (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clr_i    (grant_d | grant_i),
    .en_i     (mem_req_o & ~mem_ack_i),
    .expired_o(expired)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state       <= IDLE;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      if_rdata_o  <= '0;
      if_valid_o  <= 1'b0;
      d_rdata_o   <= '0;
      d_valid_o   <= 1'b0;
      err_o       <= 1'b0;
    end else begin
      if_valid_o <= 1'b0;
      d_valid_o  <= 1'b0;

      if (done) begin
        if (state == IBUSY) begin
          if_valid_o <= 1'b1;
          if_rdata_o <= ack ? mem_rdata_i : '0;
        end else begin
          d_valid_o <= 1'b1;
          if (!mem_we_o) begin
            d_rdata_o <= ack ? mem_rdata_i : '0;
          end
        end
        if (timeout) begin
          err_o <= 1'b1;
        end
      end

      if (grant_d) begin
        state       <= DBUSY;
        mem_req_o   <= 1'b1;
        mem_we_o    <= d_we_i;
        mem_addr_o  <= d_addr_i;
        mem_wdata_o <= d_wdata_i;
      end else if (grant_i) begin
        state       <= IBUSY;
        mem_req_o   <= 1'b1;
        mem_we_o    <= 1'b0;
        mem_addr_o  <= if_addr_i;
        mem_wdata_o <= '0;
      end else if (done) begin
        state     <= IDLE;
        mem_req_o <= 1'b0;
        mem_we_o  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed scenarios followed by randomized two-port traffic.
module tb_mem_arbiter;

  localparam int TIMEOUT  = 15;
  localparam int WAIT_MAX = 60;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          dly;
  } txn_t;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic [31:0] if_rdata_o;
  logic        if_valid_o;
  logic        if_stall_o;
  logic        d_req_i;
  logic        d_we_i;
  logic [31:0] d_addr_i;
  logic [31:0] d_wdata_i;
  logic [31:0] d_rdata_o;
  logic        d_valid_o;
  logic        d_stall_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata_i = 32'h0;
  logic        mem_ack_i = 1'b0;
  logic        err_o;

  txn_t i_resp_q[$];
  txn_t d_resp_q[$];
  txn_t i_mon_q[$];
  txn_t d_mon_q[$];

  int          n_checks = 0;
  int          n_pass = 0;
  bit          force_ack = 1'b0;
  bit          spur_en = 1'b0;
  bit          err_m = 1'b0;
  logic [31:0] last_d = 32'h0;

  mem_arbiter #(
    .AW(32),
    .DW(32),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .if_req_i   (if_req_i),
    .if_addr_i  (if_addr_i),
    .if_rdata_o (if_rdata_o),
    .if_valid_o (if_valid_o),
    .if_stall_o (if_stall_o),
    .d_req_i    (d_req_i),
    .d_we_i     (d_we_i),
    .d_addr_i   (d_addr_i),
    .d_wdata_i  (d_wdata_i),
    .d_rdata_o  (d_rdata_o),
    .d_valid_o  (d_valid_o),
    .d_stall_o  (d_stall_o),
    .mem_req_o  (mem_req_o),
    .mem_we_o   (mem_we_o),
    .mem_addr_o (mem_addr_o),
    .mem_wdata_o(mem_wdata_o),
    .mem_rdata_i(mem_rdata_i),
    .mem_ack_i  (mem_ack_i),
    .err_o      (err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
  endtask

  function automatic int rnd_dly();
    if ($urandom_range(0, 9) < 7) return int'($urandom_range(0, 3));
    return int'($urandom_range(TIMEOUT - 1, TIMEOUT + 3));
  endfunction

  // Memory model: acks after the transaction's chosen number of wait cycles; the DUT gives up
  // after the busy cycle with TIMEOUT waits behind it, so longer delays never see an ack.
  bit   active = 1'b0;
  txn_t cur;
  int   idx = 0;
  always @(negedge clk_i) begin
    mem_ack_i   = 1'b0;
    mem_rdata_i = $urandom;
    if (!rst_i) begin
      active = 1'b0;
    end else if (mem_req_o) begin
      if (!active) begin
        if (d_resp_q.size() > 0 && d_resp_q[0].addr == mem_addr_o) begin
          cur = d_resp_q.pop_front();
          active = 1'b1;
        end else if (i_resp_q.size() > 0 && i_resp_q[0].addr == mem_addr_o) begin
          cur = i_resp_q.pop_front();
          active = 1'b1;
        end
        chk("mem_addr_matches_pending", 32'(active), 32'(1));
        if (active) begin
          chk("mem_we", 32'(mem_we_o), 32'(cur.we));
          if (cur.we) chk("mem_wdata", mem_wdata_o, cur.wdata);
          idx = 0;
        end
      end
      if (active) begin
        if (idx == cur.dly) begin
          mem_ack_i   = 1'b1;
          mem_rdata_i = cur.rdata;
          active      = 1'b0;
        end else if (idx == TIMEOUT) begin
          active = 1'b0;
        end else begin
          idx++;
        end
      end
    end else begin
      if (active) chk("mem_req_held", 32'(mem_req_o), 32'(1));
      active    = 1'b0;
      mem_ack_i = force_ack | (spur_en && $urandom_range(0, 3) == 0);
    end
  end

  always @(negedge clk_i) begin : monitor
    txn_t e;
    if (!rst_i) begin
      err_m  = 1'b0;
      last_d = 32'h0;
    end else begin
      if (if_valid_o) begin
        chk("if_valid_expected", 32'(i_mon_q.size() > 0), 32'(1));
        if (i_mon_q.size() > 0) begin
          e = i_mon_q.pop_front();
          if (e.dly > TIMEOUT) err_m = 1'b1;
          chk("if_rdata", if_rdata_o, (e.dly > TIMEOUT) ? 32'h0 : e.rdata);
          chk("err_at_if_valid", 32'(err_o), 32'(err_m));
        end
      end
      if (d_valid_o) begin
        chk("d_valid_expected", 32'(d_mon_q.size() > 0), 32'(1));
        if (d_mon_q.size() > 0) begin
          e = d_mon_q.pop_front();
          if (e.dly > TIMEOUT) err_m = 1'b1;
          if (!e.we) last_d = (e.dly > TIMEOUT) ? 32'h0 : e.rdata;
          chk("d_rdata", d_rdata_o, last_d);
          chk("err_at_d_valid", 32'(err_o), 32'(err_m));
        end
      end
    end
  end

  task automatic do_req(input bit is_d, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] rdata, input int dly,
                        output int lat);
    txn_t t;
    bit   got;
    t.we = we; t.addr = addr; t.wdata = wdata; t.rdata = rdata; t.dly = dly;
    if (is_d) begin
      d_resp_q.push_back(t);
      d_mon_q.push_back(t);
      d_we_i = we; d_addr_i = addr; d_wdata_i = wdata; d_req_i = 1'b1;
    end else begin
      i_resp_q.push_back(t);
      i_mon_q.push_back(t);
      if_addr_i = addr; if_req_i = 1'b1;
    end
    lat = 0;
    got = 1'b0;
    while (!got && lat < WAIT_MAX) begin
      @(posedge clk_i); #1;
      lat++;
      if (is_d) begin
        got = d_valid_o;
        chk("d_stall", 32'(d_stall_o), 32'(!got));
      end else begin
        got = if_valid_o;
        chk("if_stall", 32'(if_stall_o), 32'(!got));
      end
    end
    chk("valid_within_bound", 32'(got), 32'(1));
    @(posedge clk_i); #1;
    if (is_d) d_req_i = 1'b0;
    else if_req_i = 1'b0;
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_i); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   lat;
    int   lat_d;
    int   lat_i;
    txn_t t;
    rst_i = 1'b0;
    if_req_i = 1'b0; if_addr_i = 32'h0;
    d_req_i = 1'b0; d_we_i = 1'b0; d_addr_i = 32'h0; d_wdata_i = 32'h0;
    tick(2);
    chk("rst_ctrl_outs", 32'({mem_req_o, mem_we_o, if_valid_o, d_valid_o, err_o}), 32'(0));
    chk("rst_if_rdata", if_rdata_o, 32'h0);
    chk("rst_d_rdata", d_rdata_o, 32'h0);
    rst_i = 1'b1;
    tick(2);

    // Lone fetch with first-cycle ack.
    do_req(1'b0, 1'b0, 32'h40, 32'h0, 32'h8C01_0004, 0, lat);
    chk("fetch_latency", 32'(lat), 32'(2));
    tick(2);

    // Simultaneous data write and fetch: data first, fetch handed over without IDLE.
    fork
      do_req(1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF, 32'h0, 0, lat_d);
      do_req(1'b0, 1'b0, 32'h44, 32'h0, 32'h1234_5678, 0, lat_i);
    join
    chk("prio_d_latency", 32'(lat_d), 32'(2));
    chk("prio_i_latency", 32'(lat_i), 32'(3));
    tick(2);

    // Ack on the last cycle before giving up counts as a normal completion.
    do_req(1'b1, 1'b0, 32'h200, 32'h0, 32'h0BAD_F00D, TIMEOUT, lat);
    chk("exact_timeout_latency", 32'(lat), 32'(TIMEOUT + 2));
    chk("exact_timeout_no_err", 32'(err_o), 32'(0));

    // Spurious ack while idle.
    force_ack = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick(1);
      chk("spur_mem_req", 32'(mem_req_o), 32'(0));
      chk("spur_valids", 32'({if_valid_o, d_valid_o}), 32'(0));
    end
    force_ack = 1'b0;
    do_req(1'b0, 1'b0, 32'h80, 32'h0, 32'h7777_1111, 0, lat);
    chk("after_spur_latency", 32'(lat), 32'(2));

    // Data read that never gets an ack.
    do_req(1'b1, 1'b0, 32'h300, 32'h0, 32'h5555_AAAA, TIMEOUT + 5, lat);
    chk("timeout_latency", 32'(lat), 32'(TIMEOUT + 2));
    tick(4);
    chk("err_sticky_idle", 32'(err_o), 32'(1));
    do_req(1'b1, 1'b0, 32'h304, 32'h0, 32'hCAFE_0001, 1, lat);
    chk("err_sticky_after_ok", 32'(err_o), 32'(1));

    // Reset in the middle of a data transaction, then a stray ack.
    t.we = 1'b0; t.addr = 32'h308; t.wdata = 32'h0; t.rdata = 32'h1111_2222; t.dly = 100;
    d_resp_q.push_back(t);
    d_mon_q.push_back(t);
    d_we_i = 1'b0; d_addr_i = 32'h308; d_req_i = 1'b1;
    tick(5);
    chk("mid_dbusy_req", 32'(mem_req_o), 32'(1));
    rst_i = 1'b0;
    d_req_i = 1'b0;
    #1;
    chk("arst_ctrl_outs", 32'({mem_req_o, mem_we_o, if_valid_o, d_valid_o, err_o}), 32'(0));
    chk("arst_mem_addr", mem_addr_o, 32'h0);
    chk("arst_mem_wdata", mem_wdata_o, 32'h0);
    chk("arst_if_rdata", if_rdata_o, 32'h0);
    chk("arst_d_rdata", d_rdata_o, 32'h0);
    d_resp_q.delete();
    d_mon_q.delete();
    tick(2);
    rst_i = 1'b1;
    force_ack = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick(1);
      chk("post_rst_ctrl", 32'({mem_req_o, if_valid_o, d_valid_o, err_o}), 32'(0));
      chk("post_rst_d_rdata", d_rdata_o, 32'h0);
    end
    force_ack = 1'b0;
    do_req(1'b0, 1'b0, 32'hC0, 32'h0, 32'h2468_ACE0, 0, lat);
    chk("post_rst_fetch_latency", 32'(lat), 32'(2));
    tick(2);

    // Randomized concurrent traffic from both ports.
    spur_en = 1'b1;
    fork
      begin
        int li;
        for (int k = 0; k < 40; k++) begin
          tick($urandom_range(0, 3));
          do_req(1'b0, 1'b0, 32'h1000_0000 | ($urandom & 32'hFFFC), 32'h0, $urandom,
                 rnd_dly(), li);
        end
      end
      begin
        int ld;
        for (int k = 0; k < 40; k++) begin
          tick($urandom_range(0, 3));
          do_req(1'b1, 1'($urandom_range(0, 1)), 32'h2000_0000 | ($urandom & 32'hFFFC),
                 $urandom, $urandom, rnd_dly(), ld);
        end
      end
    join
    spur_en = 1'b0;
    tick(4);
    chk("i_queue_drained", 32'(i_mon_q.size()), 32'(0));
    chk("d_queue_drained", 32'(d_mon_q.size()), 32'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
